// File: rtl/hazard_control_unit.sv
// rtl/hazard_control_unit.sv - pipeline stall/flush controller with halt drain and perf counters
module hazard_control_unit #(
    parameter int CNT_W = 16
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             ihit,
    input  logic             dhit,
    input  logic             de_mem_read,
    input  logic             de_reg_write,
    input  logic [4:0]       de_wsel,
    input  logic [4:0]       dec_rsel1,
    input  logic [4:0]       dec_rsel2,
    input  logic             dec_use1,
    input  logic             dec_use2,
    input  logic             ex_redirect,
    input  logic             xm_mem_req,
    input  logic             xm_halt,
    output logic             fd_stall,
    output logic             fd_flush,
    output logic             de_stall,
    output logic             de_flush,
    output logic             xm_stall,
    output logic             xm_flush,
    output logic             pc_en,
    output logic             halted,
    output logic [CNT_W-1:0] lu_count,
    output logic [CNT_W-1:0] redir_count,
    output logic [CNT_W-1:0] dwait_count
);

    typedef enum logic [1:0] {RUN, DRAIN, HALTED} state_e;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_e state_q, state_d, cur_state;
    logic [CNT_W-1:0] lu_q, redir_q, dwait_q;
    logic mem_wait, load_use;
    logic rule_wait, rule_redir, rule_lu, count_en;

    assign mem_wait = xm_mem_req & ~dhit;
    assign load_use = de_mem_read & de_reg_write & (de_wsel != 5'd0) &
                      ((dec_use1 & (dec_rsel1 == de_wsel)) |
                       (dec_use2 & (dec_rsel2 == de_wsel)));

    // While reset is asserted the controls behave as in RUN, whatever the stored state.
    assign cur_state  = nRST ? state_q : RUN;
    assign count_en   = (cur_state != HALTED);
    assign rule_wait  = mem_wait;
    assign rule_redir = ~mem_wait & ex_redirect;
    assign rule_lu    = ~mem_wait & ~ex_redirect & load_use;

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN:     if (xm_halt)   state_d = DRAIN;
            DRAIN:   if (!mem_wait) state_d = HALTED;
            HALTED:  state_d = HALTED;
            default: state_d = RUN;
        endcase
    end

    always_comb begin
        fd_stall = 1'b0;
        fd_flush = 1'b0;
        de_stall = 1'b0;
        de_flush = 1'b0;
        xm_stall = 1'b0;
        xm_flush = 1'b0;
        pc_en    = 1'b0;
        if (cur_state == HALTED) begin
            fd_stall = 1'b1;
            de_stall = 1'b1;
            xm_stall = 1'b1;
        end else begin
            if (rule_wait) begin
                fd_stall = 1'b1;
                de_stall = 1'b1;
                xm_stall = 1'b1;
            end else if (rule_redir) begin
                fd_flush = 1'b1;
                de_flush = 1'b1;
                pc_en    = 1'b1;
            end else if (rule_lu) begin
                fd_stall = 1'b1;
                de_flush = 1'b1;
            end else if (!ihit) begin
                fd_flush = 1'b1;
            end else begin
                pc_en    = 1'b1;
            end
            // Draining: stop fetching and keep bubbles flowing into decode.
            if (cur_state == DRAIN) begin
                pc_en    = 1'b0;
                fd_flush = 1'b1;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            lu_q    <= '0;
            redir_q <= '0;
            dwait_q <= '0;
        end else if (count_en) begin
            if (rule_lu && lu_q != '1)       lu_q    <= lu_q + CNT_ONE;
            if (rule_redir && redir_q != '1) redir_q <= redir_q + CNT_ONE;
            if (rule_wait && dwait_q != '1)  dwait_q <= dwait_q + CNT_ONE;
        end
    end

    assign halted      = (state_q == HALTED);
    assign lu_count    = lu_q;
    assign redir_count = redir_q;
    assign dwait_count = dwait_q;

endmodule
